// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM state encoding for the direct-mapped data cache.
// 8 lines of 4 bytes; byte address = {tag[2:0], index[2:0], offset[1:0]}.
package data_cache_pkg;

    localparam int NUM_LINES    = 8;
    localparam int TAG_W        = 3;
    localparam int INDEX_W      = 3;
    localparam int OFFSET_W     = 2;
    localparam int BYTE_W       = 8;
    localparam int ADDR_W       = TAG_W + INDEX_W + OFFSET_W;
    localparam int BLOCK_ADDR_W = TAG_W + INDEX_W;
    localparam int LINE_W       = BYTE_W << OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    // Byte lane k of a line lives in bits [8k+7:8k].
    function automatic logic [BYTE_W-1:0] select_byte(input logic [LINE_W-1:0] line,
                                                      input logic [OFFSET_W-1:0] offset);
        return line[{offset, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache.
// The slave view is the cache itself; the master view is the CPU plus data memory around it.
interface data_cache_if;
    import data_cache_pkg::*;

    logic                    read;
    logic                    write;
    logic [ADDR_W-1:0]       address;
    logic [BYTE_W-1:0]       writedata;
    logic [BYTE_W-1:0]       readdata;
    logic                    busywait;

    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0]       mem_writedata;
    logic [LINE_W-1:0]       mem_readdata;
    logic                    mem_busywait;

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/data_cache_fsm.sv
// Miss-handling controller: state register plus registered memory strobes.
// Strobes are set on entry to WRITEBACK/FETCH so they are never both high and are 0 in IDLE.
module data_cache_fsm
    import data_cache_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   request,
    input  logic   hit,
    input  logic   victim_dirty,
    input  logic   mem_busywait,
    output state_t state,
    output logic   mem_read,
    output logic   mem_write
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (victim_dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state     <= FETCH;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a block memory.
// The request is not latched: the CPU holds it stable while busywait is high.
module data_cache
    import data_cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    data_cache_if.slave bus
);

    logic [LINE_W-1:0]   line_data [NUM_LINES];
    logic [TAG_W-1:0]    line_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic                request;
    logic                store;
    logic                write_hit;
    logic                refill;
    state_t              state;
    logic                mem_read;
    logic                mem_write;

    assign tag    = bus.address[ADDR_W-1 -: TAG_W];
    assign index  = bus.address[OFFSET_W +: INDEX_W];
    assign offset = bus.address[OFFSET_W-1:0];

    assign hit       = valid[index] && (line_tag[index] == tag);
    assign request   = bus.read || bus.write;
    // A simultaneous read and write is served as a plain read.
    assign store     = bus.write && !bus.read;
    assign write_hit = (state == IDLE) && store && hit;
    assign refill    = (state == FETCH) && !bus.mem_busywait;

    assign bus.busywait      = request && !((state == IDLE) && hit);
    assign bus.readdata      = select_byte(line_data[index], offset);
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_address   = (state == WRITEBACK) ? {line_tag[index], index} : {tag, index};
    assign bus.mem_writedata = line_data[index];

    data_cache_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .hit          (hit),
        .victim_dirty (valid[index] && dirty[index]),
        .mem_busywait (bus.mem_busywait),
        .state        (state),
        .mem_read     (mem_read),
        .mem_write    (mem_write)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (refill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    // NOTE: the data and tag arrays are deliberately not reset; valid bits alone
    // make stale contents unreachable, and this lets the arrays map onto RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (refill) begin
                line_data[index] <= bus.mem_readdata;
                line_tag[index]  <= tag;
            end else if (write_hit) begin
                line_data[index][{offset, 3'b000} +: BYTE_W] <= bus.writedata;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache: a flat byte-addressed golden memory
// gives read data, and a per-index residency table predicts hits, writebacks and fetches.
module tb_data_cache;
    import data_cache_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    data_cache_if bus();

    data_cache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Backing data memory with a programmable stall length per access.
    logic [31:0] mem_words [64];
    int unsigned lat = 0;
    int unsigned cnt = 0;

    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < lat);
    assign bus.mem_readdata = mem_words[bus.mem_address];

    always @(posedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (cnt >= lat) begin
                cnt <= 0;
                if (bus.mem_write) mem_words[bus.mem_address] <= bus.mem_writedata;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Reference model: what a CPU should observe, plus which blocks are resident.
    logic [7:0] golden  [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [2:0] m_tag   [8];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // After reset the cache forgets everything; what memory holds is the truth.
    task automatic model_reset();
        logic [31:0] w;
        for (int b = 0; b < 256; b++) begin
            w = mem_words[b >> 2];
            golden[b] = w[(b % 4) * 8 +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        #1;
        check("reset_busywait", bus.busywait, 0);
        check("reset_strobes", {bus.mem_read, bus.mem_write}, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [5:0]  victim;
        logic [31:0] victim_exp;
        bit          exp_miss, exp_wb, first_busy, wb_seen, rd_seen, both;
        logic [5:0]  wb_addr, rd_addr;
        logic [31:0] wb_data;
        int          busy_n, stall_n, cyc;

        idx        = a[4:2];
        tg         = a[7:5];
        exp_miss   = !(m_valid[idx] && m_tag[idx] == tg);
        exp_wb     = exp_miss && m_valid[idx] && m_dirty[idx];
        victim     = {m_tag[idx], idx};
        victim_exp = {golden[{victim, 2'd3}], golden[{victim, 2'd2}],
                      golden[{victim, 2'd1}], golden[{victim, 2'd0}]};

        @(negedge clk);
        lat           = $urandom_range(0, 3);
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        #1;
        first_busy = bus.busywait;
        wb_seen = 0; rd_seen = 0; both = 0;
        wb_addr = '0; rd_addr = '0; wb_data = '0;
        busy_n = 0; stall_n = 0; cyc = 0;
        while (bus.busywait && cyc < 200) begin
            if (bus.mem_write && !wb_seen) begin
                wb_seen = 1;
                wb_addr = bus.mem_address;
                wb_data = bus.mem_writedata;
            end
            if (bus.mem_read) begin
                rd_seen = 1;
                rd_addr = bus.mem_address;
            end
            if (bus.mem_read && bus.mem_write) both = 1;
            if (bus.mem_busywait) stall_n++;
            busy_n++;
            @(negedge clk);
            #1;
            cyc++;
        end

        check("served", bus.busywait, 0);
        check("miss", first_busy, exp_miss);
        check("writeback", wb_seen, exp_wb);
        if (exp_wb) begin
            check("wb_address", wb_addr, victim);
            check("wb_data", wb_data, victim_exp);
        end
        check("fetch", rd_seen, exp_miss);
        if (exp_miss) check("fetch_address", rd_addr, a[7:2]);
        check("latency", busy_n, exp_miss ? 2 + stall_n + int'(exp_wb) : 0);
        check("strobe_overlap", both, 0);
        check("strobes_done", {bus.mem_read, bus.mem_write}, 0);
        if (rd) check("readdata", bus.readdata, golden[a]);

        if (exp_miss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr && !rd) begin
            golden[a]    = d;
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        bit bad;
        int op;
        logic [7:0] a;

        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        for (int i = 0; i < 64; i++) mem_words[i] = $urandom;
        mem_words[5] = 32'h4433_2211;

        do_reset();

        // Cold read miss, then hits in the refilled line.
        access(1, 0, 8'h14, 8'h00);
        check("first_byte", bus.readdata, 8'h11);
        access(1, 0, 8'h17, 8'h00);
        check("last_byte", bus.readdata, 8'h44);
        access(0, 1, 8'h15, 8'hAA);
        access(1, 0, 8'h15, 8'h00);
        check("stored_byte", bus.readdata, 8'hAA);

        // Conflict miss evicts the dirty line before fetching block 0x2D.
        access(1, 0, 8'hB4, 8'h00);
        check("mem_after_wb", mem_words[5], 32'h4433_AA11);

        // Reset in the middle of a fetch aborts it.
        @(negedge clk);
        lat         = 3;
        bus.read    = 1'b1;
        bus.address = 8'h14;
        @(negedge clk);
        #1;
        check("fetch_started", bus.mem_read, 1);
        reset    = 1'b1;
        bus.read = 1'b0;
        @(negedge clk);
        #1;
        check("abort_strobes", {bus.mem_read, bus.mem_write}, 0);
        reset = 1'b0;
        model_reset();
        access(1, 0, 8'h14, 8'h00);

        // Quiet bus with no request.
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.busywait || bus.mem_read || bus.mem_write) bad = 1;
        end
        check("idle_quiet", bad, 0);

        // Random traffic over a few tags so hits, clean and dirty misses all occur.
        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            a[7:5] = $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (op < 4)       access(1, 0, a, 8'h00);
            else if (op < 9)  access(0, 1, a, 8'($urandom));
            else              access(1, 1, a, 8'($urandom));
            if (n == 200) do_reset();
        end

        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
